// File: rtl/core_decode_stage_if.sv
// Fetch/execute handshake bundle for the decode stage.
// master drives fetch words, flags, flush and out_ready; slave is the decode stage.
interface core_decode_stage_if #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 30
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_insn;
    logic [PTR_WIDTH-1:0] in_pc;
    logic [3:0]           flags;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_execute;
    logic                 out_undefined;
    logic                 out_writeback;
    logic                 out_branch;
    logic [PTR_WIDTH-1:0] out_branch_target;
    logic [3:0]           out_rd;
    logic [PTR_WIDTH-1:0] out_pc;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output in_valid, in_insn, in_pc, flags, flush, out_ready,
        input  in_ready, out_valid, out_execute, out_undefined, out_writeback,
               out_branch, out_branch_target, out_rd, out_pc, occupancy
    );

    modport slave (
        input  in_valid, in_insn, in_pc, flags, flush, out_ready,
        output in_ready, out_valid, out_execute, out_undefined, out_writeback,
               out_branch, out_branch_target, out_rd, out_pc, occupancy
    );
endinterface

// File: rtl/core_decode_stage.sv
// Buffered decode stage: DEPTH-entry instruction queue feeding a registered
// decode slot; condition evaluation against live flags stays combinational.
module core_decode_stage #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    core_decode_stage_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [31:0]          insn_mem [DEPTH];
    logic [PTR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     count;

    logic                 out_valid, out_undefined, out_writeback, out_branch;
    logic [PTR_WIDTH-1:0] out_branch_target, out_pc;
    logic [3:0]           out_rd, cond_q;

    logic                 in_ready, enq, load;
    logic [31:0]          h_insn;
    logic [PTR_WIDTH-1:0] h_pc;
    logic                 d_undef, d_wb, d_branch;
    logic [PTR_WIDTH-1:0] d_target;
    logic [3:0]           d_rd;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = cf;
            4'h3: cond_pass = !cf;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = cf && !z;
            4'h9: cond_pass = !cf || z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign in_ready = (count < OCC_W'(DEPTH));
    assign enq      = bus.in_valid && in_ready && !bus.flush;
    assign load     = (count != '0) && (!out_valid || bus.out_ready);

    always_comb begin
        h_insn   = insn_mem[rd_ptr];
        h_pc     = pc_mem[rd_ptr];
        d_undef  = (h_insn[31:28] == 4'hF) || (h_insn[27:25] == 3'b011 && h_insn[4]);
        d_wb     = 1'b0;
        d_branch = 1'b0;
        d_rd     = '0;
        d_target = '0;
        if (h_insn[27:25] == 3'b101) begin
            d_branch = 1'b1;
            d_target = h_pc + PTR_WIDTH'(2)
                     + {{(PTR_WIDTH-24){h_insn[23]}}, h_insn[23:0]};
            if (h_insn[24]) begin
                d_wb = 1'b1;
                d_rd = 4'd14;
            end
        end else if (h_insn[27:26] == 2'b00
                     && !(!h_insn[25] && h_insn[7] && h_insn[4])
                     && !(h_insn[24:23] == 2'b10 && !h_insn[20])) begin
            // With S=1 forced by the MRS/MSR exclusion, opcode 10xx is TST..CMN.
            d_rd = h_insn[15:12];
            d_wb = (h_insn[24:23] != 2'b10);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            insn_mem[wr_ptr] <= bus.in_insn;
            pc_mem[wr_ptr]   <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            out_valid         <= 1'b0;
            out_undefined     <= 1'b0;
            out_writeback     <= 1'b0;
            out_branch        <= 1'b0;
            out_branch_target <= '0;
            out_rd            <= '0;
            out_pc            <= '0;
            cond_q            <= '0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                out_valid         <= 1'b1;
                out_undefined     <= d_undef;
                out_writeback     <= d_wb;
                out_branch        <= d_branch;
                out_branch_target <= d_target;
                out_rd            <= d_rd;
                out_pc            <= h_pc;
                cond_q            <= h_insn[31:28];
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.occupancy         = count;
    assign bus.out_valid         = out_valid;
    assign bus.out_execute       = out_valid && cond_pass(cond_q, bus.flags);
    assign bus.out_undefined     = out_undefined;
    assign bus.out_writeback     = out_writeback;
    assign bus.out_branch        = out_branch;
    assign bus.out_branch_target = out_branch_target;
    assign bus.out_rd            = out_rd;
    assign bus.out_pc            = out_pc;
endmodule

// File: tb/tb_core_decode_stage.sv
// Self-checking bench for core_decode_stage: directed scenarios plus a
// randomized run checked against an in-order scoreboard and decode model.
module tb_core_decode_stage;
    localparam int DEPTH = 4;
    localparam int PW    = 30;

    typedef struct packed {
        logic          undef;
        logic          wb;
        logic          br;
        logic [PW-1:0] tgt;
        logic [3:0]    rd;
    } exp_t;

    typedef struct {
        logic [31:0]   insn;
        logic [PW-1:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    core_decode_stage_if #(.DEPTH(DEPTH), .PTR_WIDTH(PW)) bus ();

    core_decode_stage #(.DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0: return z;         1: return !z;
            2: return cy;        3: return !cy;
            4: return n;         5: return !n;
            6: return v;         7: return !v;
            8: return cy & !z;   9: return !cy | z;
            10: return n == v;   11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [PW-1:0] pc);
        exp_t e;
        longint t;
        bit is_mul, is_psr;
        e = '0;
        e.undef = (w[31:28] == 4'd15) || (w[27:25] == 3'd3 && w[4] == 1'b1);
        is_mul = (w[25] == 1'b0) && w[7] && w[4];
        is_psr = (w[24:23] == 2'd2) && (w[20] == 1'b0);
        if (w[27:25] == 3'd5) begin
            t = longint'(pc) + 2 + longint'($signed(w[23:0]));
            e.br  = 1'b1;
            e.tgt = t[PW-1:0];
            if (w[24]) begin e.wb = 1'b1; e.rd = 4'd14; end
        end else if (w[27:26] == 2'd0 && !is_mul && !is_psr) begin
            e.rd = w[15:12];
            e.wb = !(w[24:21] >= 4'd8 && w[24:21] <= 4'd11);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_insn   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.flags     = 4'h0;
    endtask

    task automatic push_one(input logic [31:0] w, input logic [PW-1:0] pc);
        bus.in_valid = 1'b1;
        bus.in_insn  = w;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.occupancy} !== {1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_handshake got v=%b rdy=%b occ=%0d want v=0 rdy=1 occ=0",
                     bus.out_valid, bus.in_ready, bus.occupancy);
        end
        checks++;
        if ({bus.out_execute, bus.out_undefined, bus.out_writeback, bus.out_branch,
             bus.out_branch_target, bus.out_rd, bus.out_pc} !== '0) begin
            errors++;
            $display("FAIL reset_fields got ex=%b ud=%b wb=%b br=%b tgt=%h rd=%h pc=%h want all 0",
                     bus.out_execute, bus.out_undefined, bus.out_writeback, bus.out_branch,
                     bus.out_branch_target, bus.out_rd, bus.out_pc);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_branch();
        push_one(32'hEA000004, 30'h100);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_latency out_valid=%b one edge after accept, want 0", bus.out_valid);
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_branch, bus.out_branch_target, bus.out_execute, bus.out_writeback}
            !== {1'b1, 1'b1, 30'h106, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b_decode got v=%b br=%b tgt=%h ex=%b wb=%b want 1 1 106 1 0",
                     bus.out_valid, bus.out_branch, bus.out_branch_target, bus.out_execute,
                     bus.out_writeback);
        end
        step();
        push_one(32'hEBFFFFFE, 30'h10);
        step();
        checks++;
        if ({bus.out_rd, bus.out_writeback, bus.out_branch_target} !== {4'd14, 1'b1, 30'h10}) begin
            errors++;
            $display("FAIL bl_decode got rd=%0d wb=%b tgt=%h want 14 1 10",
                     bus.out_rd, bus.out_writeback, bus.out_branch_target);
        end
        step();
        push_one(32'hEBFFFFFD, 30'h0);
        step();
        checks++;
        if (bus.out_branch_target !== 30'h3FFFFFFF) begin
            errors++;
            $display("FAIL bl_wrap got tgt=%h want 3fffffff", bus.out_branch_target);
        end
        step();
    endtask

    task automatic test_cond_stall();
        bus.flags     = 4'b0000;
        bus.out_ready = 1'b0;
        push_one(32'h00812003, 30'h20);
        step();
        checks++;
        if ({bus.out_valid, bus.out_execute, bus.out_rd, bus.out_writeback}
            !== {1'b1, 1'b0, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL addeq_z0 got v=%b ex=%b rd=%0d wb=%b want 1 0 2 1",
                     bus.out_valid, bus.out_execute, bus.out_rd, bus.out_writeback);
        end
        bus.flags = 4'b0100;
        step();
        step();
        checks++;
        if ({bus.out_valid, bus.out_execute, bus.out_rd, bus.out_pc} !== {1'b1, 1'b1, 4'd2, 30'h20}) begin
            errors++;
            $display("FAIL addeq_z1_stall got v=%b ex=%b rd=%0d pc=%h want 1 1 2 20",
                     bus.out_valid, bus.out_execute, bus.out_rd, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        step();
        push_one(32'hE1510002, 30'h24);
        step();
        checks++;
        if ({bus.out_valid, bus.out_writeback, bus.out_execute} !== {1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cmp_wb got v=%b wb=%b ex=%b want 1 0 1",
                     bus.out_valid, bus.out_writeback, bus.out_execute);
        end
        step();
    endtask

    task automatic fill_full(output int accepted);
        accepted = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_insn  = 32'hE1A00000 | (32'(i) << 12);
            bus.in_pc    = PW'(i);
            if (bus.in_ready) accepted++;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_full_drain();
        int acc;
        fill_full(acc);
        checks++;
        if (acc !== DEPTH + 1 || bus.occupancy !== 3'(DEPTH) || bus.in_ready !== 1'b0
            || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_state got acc=%0d occ=%0d rdy=%b v=%b want %0d %0d 0 1",
                     acc, bus.occupancy, bus.in_ready, bus.out_valid, DEPTH + 1, DEPTH);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_rd, bus.out_pc} !== {1'b1, 4'(i), PW'(i)}) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%b rd=%0d pc=%h want 1 %0d %h",
                         i, bus.out_valid, bus.out_rd, bus.out_pc, i, i);
            end
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b occ=%0d want 0 0", bus.out_valid, bus.occupancy);
        end
    endtask

    task automatic test_flush();
        int acc;
        fill_full(acc);
        bus.in_valid = 1'b1;
        bus.in_insn  = 32'hE1A0F000;
        bus.in_pc    = 30'h3C;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.occupancy, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_state got occ=%0d v=%b rdy=%b want 0 0 1",
                     bus.occupancy, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_dropped[%0d] got v=%b rd=%0d want v=0", i, bus.out_valid, bus.out_rd);
            end
        end
    endtask

    task automatic test_undefined();
        bus.flags = 4'hF;
        push_one(32'hF0000000, 30'h40);
        step();
        checks++;
        if ({bus.out_valid, bus.out_undefined, bus.out_execute} !== {1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL undef_cond got v=%b ud=%b ex=%b want 1 1 0",
                     bus.out_valid, bus.out_undefined, bus.out_execute);
        end
        step();
        push_one(32'hE6000010, 30'h44);
        step();
        checks++;
        if ({bus.out_valid, bus.out_undefined, bus.out_writeback, bus.out_branch, bus.out_rd}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL undef_media got v=%b ud=%b wb=%b br=%b rd=%0d want 1 1 0 0 0",
                     bus.out_valid, bus.out_undefined, bus.out_writeback, bus.out_branch, bus.out_rd);
        end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push_one(32'hE1A03000, 30'h50);
        push_one(32'hE1A04000, 30'h54);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.occupancy, bus.out_rd} !== {1'b0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset got v=%b occ=%0d rd=%0d want 0 0 0",
                     bus.out_valid, bus.occupancy, bus.out_rd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
    endtask

    function automatic logic [31:0] gen_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: ;
            1: w[27:25] = 3'b101;
            2: w[27:26] = 2'b00;
            3: begin w[27:25] = 3'b000; w[7] = 1'b1; w[4] = 1'b1; end
            4: w[27:25] = 3'b011;
            default: begin w[27:26] = 2'b00; w[24:23] = 2'b10; w[20] = 1'b0; end
        endcase
        return w;
    endfunction

    task automatic test_random();
        item_t sb[$];
        item_t it;
        exp_t  e, got;
        bit    acc, con;
        int    model_occ;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.flags     = 4'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_insn   = gen_insn();
            bus.in_pc     = PW'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            #1;
            model_occ = sb.size() - ((sb.size() > 0 && bus.out_valid === 1'b1) ? 1 : 0);
            checks++;
            if (bus.occupancy !== 3'(model_occ) || bus.in_ready !== (model_occ < DEPTH)) begin
                errors++;
                $display("FAIL rand_occ cyc=%0d got occ=%0d rdy=%b want occ=%0d rdy=%b",
                         cyc, bus.occupancy, bus.in_ready, model_occ, model_occ < DEPTH);
            end
            if (bus.out_valid === 1'b1 && sb.size() > 0) begin
                it  = sb[0];
                e   = ref_decode(it.insn, it.pc);
                got = '{bus.out_undefined, bus.out_writeback, bus.out_branch,
                        bus.out_branch_target, bus.out_rd};
                checks++;
                if (got !== e || bus.out_pc !== it.pc
                    || bus.out_execute !== ref_cond(it.insn[31:28], bus.flags)) begin
                    errors++;
                    $display("FAIL rand_decode cyc=%0d insn=%h got %h pc=%h ex=%b want %h pc=%h ex=%b",
                             cyc, it.insn, got, bus.out_pc, bus.out_execute, e, it.pc,
                             ref_cond(it.insn[31:28], bus.flags));
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.out_execute !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle cyc=%0d got v=%b ex=%b want 0 0 (model holds %0d)",
                             cyc, bus.out_valid, bus.out_execute, sb.size());
                end
            end
            acc = bus.in_valid && bus.in_ready;
            con = bus.out_valid && bus.out_ready;
            it  = '{bus.in_insn, bus.in_pc};
            step();
            if (con && sb.size() > 0) void'(sb.pop_front());
            if (bus.flush) sb.delete();
            else if (acc) sb.push_back(it);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_cond_stall();
        test_full_drain();
        test_flush();
        test_undefined();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
